// File: rtl/python_sync_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : python_sync_pkg                                                 |
// | Brief    : PYTHON sync codes, generator FSM states and pattern modes.      |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

package python_sync_pkg;

    localparam logic [7:0] c_SYNC_TR = 8'hE9;
    localparam logic [7:0] c_SYNC_FS = 8'hAA;
    localparam logic [7:0] c_SYNC_FE = 8'hCA;
    localparam logic [7:0] c_SYNC_LS = 8'h2A;
    localparam logic [7:0] c_SYNC_LE = 8'h4A;
    localparam logic [7:0] c_SYNC_WN = 8'h13;
    localparam logic [7:0] c_SYNC_BL = 8'h05;
    localparam logic [7:0] c_SYNC_IM = 8'h0D;
    localparam logic [7:0] c_SYNC_CS = 8'h35;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GAP   = 2'd1,
        ST_BLACK = 2'd2,
        ST_IMAGE = 2'd3
    } gen_state_e;

    typedef enum logic [1:0] {
        MODE_RAMP    = 2'd0,
        MODE_VBARS   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_CONST   = 2'd3
    } pat_mode_e;

endpackage

`default_nettype wire

// File: rtl/python_pattern_gen_if.sv
// +----------------------------------------------------------------------------+
// | Module   : python_pattern_gen_if                                           |
// | Brief    : Control inputs and sensor-style word outputs of the generator.  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

interface python_pattern_gen_if #(
    parameter int LANES = 4,
    parameter int PIX_W = 8
);
    logic                     enable;
    logic                     use_trigger;
    logic                     trigger;
    logic [1:0]               mode;
    logic [PIX_W-1:0]         const_val;
    logic [LANES*PIX_W-1:0]   data;
    logic [7:0]               sync;
    logic                     frame_active;
    logic [15:0]              frame_cnt;

    modport master (
        input  enable, use_trigger, trigger, mode, const_val,
        output data, sync, frame_active, frame_cnt
    );

    modport slave (
        output enable, use_trigger, trigger, mode, const_val,
        input  data, sync, frame_active, frame_cnt
    );
endinterface

`default_nettype wire

// File: rtl/python_pattern_pixel.sv
// +----------------------------------------------------------------------------+
// | Module   : python_pattern_pixel                                            |
// | Brief    : Test-pattern value of one lane's pixel for a given row/word.    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module python_pattern_pixel
    import python_sync_pkg::*;
#(
    parameter int PIX_W = 8,
    parameter int COLS  = 64,
    parameter int LANES = 4,
    parameter int LANE  = 0
) (
    input  wire logic [15:0]      i_row,
    input  wire logic [15:0]      i_word,
    input  wire pat_mode_e        i_mode,
    input  wire logic [PIX_W-1:0] i_const_val,
    output logic      [PIX_W-1:0] o_pix
);

    logic [31:0]      w_col;
    logic [PIX_W-1:0] w_ramp;
    logic [PIX_W-1:0] w_bars;
    logic             w_check;

    always_comb begin
        w_col   = 32'(i_word) * 32'(LANES) + 32'(LANE);
        w_ramp  = PIX_W'(32'(i_row) * 32'(COLS) + w_col);
        w_bars  = PIX_W'((w_col >> 3) << 4);
        w_check = i_row[3] ^ w_col[3];
        o_pix   = '0;
        case (i_mode)
            MODE_RAMP:    o_pix = w_ramp;
            MODE_VBARS:   o_pix = w_bars;
            MODE_CHECKER: o_pix = w_check ? '1 : '0;
            MODE_CONST:   o_pix = i_const_val;
            default:      o_pix = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/python_pattern_gen.sv
// +----------------------------------------------------------------------------+
// | Module   : python_pattern_gen                                              |
// | Brief    : PYTHON sensor emulator: framed test patterns with sync codes.   |
// |            Define PYTHON_CHECKSUM_EN for per-lane line checksums on CS.    |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module python_pattern_gen
    import python_sync_pkg::*;
#(
    parameter int LANES            = 4,
    parameter int PIX_W            = 8,
    parameter int COLS             = 64,
    parameter int ROWS             = 32,
    parameter int BLACK_ROWS       = 3,
    parameter int INTERFRAME_WORDS = 8431,
    parameter int INTERLINE_WORDS  = 300,
    parameter int DATA_RST_VAL     = 0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    python_pattern_gen_if.master  bus
);

    localparam int c_W        = COLS / LANES;
    localparam int c_BLK_LEN  = c_W + 4;
    localparam int c_IMG_LEN  = c_W + 1 + INTERLINE_WORDS;
    localparam int c_LINE_MAX = (c_IMG_LEN > c_BLK_LEN) ? c_IMG_LEN : c_BLK_LEN;
    localparam int c_CNT_MAX  = (INTERFRAME_WORDS > c_LINE_MAX) ? INTERFRAME_WORDS : c_LINE_MAX;
    localparam int c_CNT_W    = $clog2(c_CNT_MAX + 1);
    localparam int c_ROW_MAX  = (ROWS > BLACK_ROWS) ? ROWS : BLACK_ROWS;
    localparam int c_ROW_W    = $clog2(c_ROW_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_K_WN1    = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_K_LE     = c_CNT_W'(c_W - 2);
    localparam logic [c_CNT_W-1:0] c_K_WN2    = c_CNT_W'(c_W - 1);
    localparam logic [c_CNT_W-1:0] c_K_CS     = c_CNT_W'(c_W);
    localparam logic [c_CNT_W-1:0] c_BLK_LAST = c_CNT_W'(c_BLK_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_IMG_LAST = c_CNT_W'(c_IMG_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST = c_CNT_W'((INTERFRAME_WORDS > 0) ? INTERFRAME_WORDS - 1 : 0);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST  = c_ROW_W'(ROWS - 1);
    localparam logic [c_ROW_W-1:0] c_BROW_LAST = c_ROW_W'((BLACK_ROWS > 0) ? BLACK_ROWS - 1 : 0);

    localparam gen_state_e             c_FIRST    = (BLACK_ROWS > 0) ? ST_BLACK : ST_IMAGE;
    localparam logic [LANES*PIX_W-1:0] c_RST_WORD = {LANES{PIX_W'(DATA_RST_VAL)}};

    gen_state_e             r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_ROW_W-1:0]     r_row;
    pat_mode_e              r_mode;
    logic                   r_trig_prev;
    logic [7:0]             r_sync;
    logic [LANES*PIX_W-1:0] r_data;
    logic                   r_frame_active;
    logic [15:0]            r_frame_cnt;

    logic [LANES*PIX_W-1:0] w_pix;
    logic [LANES*PIX_W-1:0] w_cs_img;
    logic [LANES*PIX_W-1:0] w_cs_blk;
    logic [7:0]             w_sync;
    logic [LANES*PIX_W-1:0] w_data;
    logic                   w_fa;
    logic                   w_is_fe;
    logic                   w_last_row;
    logic                   w_line_last;
    logic                   w_free;
    logic                   w_trig_edge;
    logic                   w_go_frame;
    logic                   w_go_gap;
    logic                   w_go_idle;

    assign bus.sync         = r_sync;
    assign bus.data         = r_data;
    assign bus.frame_active = r_frame_active;
    assign bus.frame_cnt    = r_frame_cnt;

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        python_pattern_pixel #(
            .PIX_W (PIX_W),
            .COLS  (COLS),
            .LANES (LANES),
            .LANE  (j)
        ) u_pixel (
            .i_row       (16'(r_row)),
            .i_word      (16'(r_cnt)),
            .i_mode      (r_mode),
            .i_const_val (bus.const_val),
            .o_pix       (w_pix[j*PIX_W +: PIX_W])
        );
    end

`ifdef PYTHON_CHECKSUM_EN
    logic [LANES*PIX_W-1:0] r_csum;

    // Restart on word 0 so the sum covers exactly the W pixel words of the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if (r_state == ST_IMAGE && r_cnt < c_K_CS) begin
            for (int j = 0; j < LANES; j++) begin
                r_csum[j*PIX_W +: PIX_W] <= ((r_cnt == '0) ? '0 : r_csum[j*PIX_W +: PIX_W])
                                            + w_pix[j*PIX_W +: PIX_W];
            end
        end
    end

    assign w_cs_img = r_csum;
    assign w_cs_blk = '0;
`else
    assign w_cs_img = c_RST_WORD;
    assign w_cs_blk = c_RST_WORD;
`endif

    assign w_last_row  = (r_row == c_ROW_LAST);
    assign w_line_last = (r_state == ST_BLACK) ? (r_cnt == c_BLK_LAST) : (r_cnt == c_IMG_LAST);
    assign w_free      = bus.enable & ~bus.use_trigger;
    assign w_trig_edge = bus.trigger & ~r_trig_prev;

    // Word decode for the current position; registered on the next edge.
    always_comb begin
        w_sync  = c_SYNC_TR;
        w_data  = c_RST_WORD;
        w_fa    = 1'b0;
        w_is_fe = 1'b0;
        case (r_state)
            ST_BLACK: begin
                if (r_cnt == '0)          w_sync = c_SYNC_LS;
                else if (r_cnt == c_K_WN1) w_sync = c_SYNC_WN;
                else if (r_cnt < c_K_LE)  w_sync = c_SYNC_BL;
                else if (r_cnt == c_K_LE)  w_sync = c_SYNC_LE;
                else if (r_cnt == c_K_WN2) w_sync = c_SYNC_WN;
                else if (r_cnt == c_K_CS) begin
                    w_sync = c_SYNC_CS;
                    w_data = w_cs_blk;
                end
            end
            ST_IMAGE: begin
                w_fa = !(w_last_row && r_cnt > c_K_LE);
                if (r_cnt < c_K_CS) w_data = w_pix;
                if (r_cnt == '0)          w_sync = (r_row == '0) ? c_SYNC_FS : c_SYNC_LS;
                else if (r_cnt == c_K_WN1) w_sync = c_SYNC_WN;
                else if (r_cnt < c_K_LE)  w_sync = c_SYNC_IM;
                else if (r_cnt == c_K_LE) begin
                    w_sync  = w_last_row ? c_SYNC_FE : c_SYNC_LE;
                    w_is_fe = w_last_row;
                end
                else if (r_cnt == c_K_WN2) w_sync = c_SYNC_WN;
                else if (r_cnt == c_K_CS) begin
                    w_sync = c_SYNC_CS;
                    w_data = w_cs_img;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        w_go_frame = 1'b0;
        w_go_gap   = 1'b0;
        w_go_idle  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_free) begin
                    if (INTERFRAME_WORDS > 0) w_go_gap   = 1'b1;
                    else                      w_go_frame = 1'b1;
                end else if (bus.enable && bus.use_trigger && w_trig_edge) begin
                    w_go_frame = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == c_GAP_LAST) w_go_frame = 1'b1;
            end
            ST_IMAGE: begin
                if (w_line_last && w_last_row) begin
                    if (w_free) begin
                        if (INTERFRAME_WORDS > 0) w_go_gap   = 1'b1;
                        else                      w_go_frame = 1'b1;
                    end else begin
                        w_go_idle = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_row          <= '0;
            r_mode         <= MODE_RAMP;
            r_trig_prev    <= 1'b0;
            r_sync         <= c_SYNC_TR;
            r_data         <= c_RST_WORD;
            r_frame_active <= 1'b0;
            r_frame_cnt    <= '0;
        end else begin
            r_trig_prev    <= bus.trigger;
            r_sync         <= w_sync;
            r_data         <= w_data;
            r_frame_active <= w_fa;
            if (w_is_fe) r_frame_cnt <= r_frame_cnt + 16'd1;

            if (w_go_frame) begin
                r_state <= c_FIRST;
                r_cnt   <= '0;
                r_row   <= '0;
                r_mode  <= pat_mode_e'(bus.mode);
            end else if (w_go_gap) begin
                r_state <= ST_GAP;
                r_cnt   <= '0;
            end else if (w_go_idle) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_row   <= '0;
            end else begin
                case (r_state)
                    ST_GAP: r_cnt <= r_cnt + c_CNT_W'(1);
                    ST_BLACK: begin
                        if (w_line_last) begin
                            r_cnt <= '0;
                            if (r_row == c_BROW_LAST) begin
                                r_row   <= '0;
                                r_state <= ST_IMAGE;
                            end else begin
                                r_row <= r_row + c_ROW_W'(1);
                            end
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    ST_IMAGE: begin
                        if (w_line_last) begin
                            r_cnt <= '0;
                            r_row <= r_row + c_ROW_W'(1);
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_python_pattern_gen.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_python_pattern_gen                                           |
// | Brief    : Directed bench for python_pattern_gen (free-run, trigger, reset).|
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_python_pattern_gen;

    localparam logic [7:0] S_TR = 8'hE9, S_FS = 8'hAA, S_FE = 8'hCA, S_LS = 8'h2A,
                           S_LE = 8'h4A, S_WN = 8'h13, S_BL = 8'h05, S_IM = 8'h0D,
                           S_CS = 8'h35;

`ifdef PYTHON_CHECKSUM_EN
    localparam logic [31:0] CS_RAMP = 32'h88807870;
    localparam logic [31:0] CS_C5   = 32'h28282828;
    localparam logic [31:0] CS_B    = 32'h000FF3FC;
`else
    localparam logic [31:0] CS_RAMP = 32'h0;
    localparam logic [31:0] CS_C5   = 32'h0;
    localparam logic [31:0] CS_B    = 32'h00055555;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    python_pattern_gen_if #(.LANES(4), .PIX_W(8))  if_a ();
    python_pattern_gen_if #(.LANES(2), .PIX_W(10)) if_b ();

    python_pattern_gen #(
        .LANES(4), .PIX_W(8), .COLS(32), .ROWS(4), .BLACK_ROWS(1),
        .INTERFRAME_WORDS(10), .INTERLINE_WORDS(3), .DATA_RST_VAL(0)
    ) u_dut_a (.clk(clk), .rst(rst), .bus(if_a));

    python_pattern_gen #(
        .LANES(2), .PIX_W(10), .COLS(20), .ROWS(10), .BLACK_ROWS(0),
        .INTERFRAME_WORDS(2), .INTERLINE_WORDS(1), .DATA_RST_VAL(341)
    ) u_dut_b (.clk(clk), .rst(rst), .bus(if_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [7:0]  sync;
        logic [31:0] data;
        logic        fa;
        logic [15:0] cnt;
    } vec_t;

    vec_t        vecs [34];
    logic [7:0]  cap_sync [300];
    logic [31:0] cap_data [300];
    logic        cap_fa   [300];
    logic [15:0] cap_cnt  [300];
    logic [7:0]  b_sync   [126];
    logic [19:0] b_data   [126];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Record DUT A one sample per cycle, #1 after each edge; then apply that cycle's stimulus.
    task automatic capture(input int n, input int mode_at, input int drop_at,
                           input int trig_a, input int trig_b);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cap_sync[c] = if_a.sync;
            cap_data[c] = if_a.data;
            cap_fa[c]   = if_a.frame_active;
            cap_cnt[c]  = if_a.frame_cnt;
            if (c == mode_at) if_a.mode = 2'd1;
            if (c == drop_at) if_a.enable = 1'b0;
            if_a.trigger = (c == trig_a || c == trig_b);
        end
    endtask

    function automatic int count_fs(input int lo, input int hi);
        int n = 0;
        for (int c = lo; c <= hi; c++) if (cap_sync[c] == S_FS) n++;
        return n;
    endfunction

    initial begin
        int bad;
        n_checks = 0;
        n_errors = 0;

        vecs[0]  = '{0,  S_TR, 32'h0, 1'b0, 16'd0};
        vecs[1]  = '{10, S_TR, 32'h0, 1'b0, 16'd0};
        vecs[2]  = '{11, S_LS, 32'h0, 1'b0, 16'd0};
        vecs[3]  = '{12, S_WN, 32'h0, 1'b0, 16'd0};
        vecs[4]  = '{13, S_BL, 32'h0, 1'b0, 16'd0};
        vecs[5]  = '{16, S_BL, 32'h0, 1'b0, 16'd0};
        vecs[6]  = '{17, S_LE, 32'h0, 1'b0, 16'd0};
        vecs[7]  = '{18, S_WN, 32'h0, 1'b0, 16'd0};
        vecs[8]  = '{19, S_CS, 32'h0, 1'b0, 16'd0};
        vecs[9]  = '{20, S_TR, 32'h0, 1'b0, 16'd0};
        vecs[10] = '{22, S_TR, 32'h0, 1'b0, 16'd0};
        vecs[11] = '{23, S_FS, 32'h03020100, 1'b1, 16'd0};
        vecs[12] = '{24, S_WN, 32'h07060504, 1'b1, 16'd0};
        vecs[13] = '{25, S_IM, 32'h0B0A0908, 1'b1, 16'd0};
        vecs[14] = '{28, S_IM, 32'h17161514, 1'b1, 16'd0};
        vecs[15] = '{29, S_LE, 32'h1B1A1918, 1'b1, 16'd0};
        vecs[16] = '{30, S_WN, 32'h1F1E1D1C, 1'b1, 16'd0};
        vecs[17] = '{31, S_CS, CS_RAMP,      1'b1, 16'd0};
        vecs[18] = '{32, S_TR, 32'h0,        1'b1, 16'd0};
        vecs[19] = '{34, S_TR, 32'h0,        1'b1, 16'd0};
        vecs[20] = '{35, S_LS, 32'h23222120, 1'b1, 16'd0};
        vecs[21] = '{49, S_IM, 32'h4B4A4948, 1'b1, 16'd0};
        vecs[22] = '{59, S_LS, 32'h63626160, 1'b1, 16'd0};
        vecs[23] = '{65, S_FE, 32'h7B7A7978, 1'b1, 16'd1};
        vecs[24] = '{66, S_WN, 32'h7F7E7D7C, 1'b0, 16'd1};
        vecs[25] = '{67, S_CS, CS_RAMP,      1'b0, 16'd1};
        vecs[26] = '{70, S_TR, 32'h0, 1'b0, 16'd1};
        vecs[27] = '{71, S_TR, 32'h0, 1'b0, 16'd1};
        vecs[28] = '{80, S_TR, 32'h0, 1'b0, 16'd1};
        vecs[29] = '{81, S_LS, 32'h0, 1'b0, 16'd1};
        vecs[30] = '{92, S_TR, 32'h0, 1'b0, 16'd1};
        vecs[31] = '{93, S_FS, 32'h0, 1'b1, 16'd1};
        vecs[32] = '{95, S_IM, 32'h10101010, 1'b1, 16'd1};
        vecs[33] = '{96, S_IM, 32'h10101010, 1'b1, 16'd1};

        rst = 1'b1;
        if_a.enable = 1'b1; if_a.use_trigger = 1'b0; if_a.trigger = 1'b0;
        if_a.mode = 2'd0;   if_a.const_val = 8'h00;
        if_b.enable = 1'b0; if_b.use_trigger = 1'b0; if_b.trigger = 1'b0;
        if_b.mode = 2'd2;   if_b.const_val = 10'h000;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sync", 32'(if_a.sync), 32'(S_TR));
        chk("rst_data", if_a.data, 32'h0);
        chk("rst_fa",   32'(if_a.frame_active), 32'h0);
        chk("rst_cnt",  32'(if_a.frame_cnt), 32'h0);
        rst = 1'b0;

        // Free-run, mode 0; mode switches to 1 mid-frame and only the second frame follows it.
        capture(97, 40, -1, -1, -1);
        foreach (vecs[i]) begin
            chk($sformatf("fr_sync@%0d", vecs[i].cyc), 32'(cap_sync[vecs[i].cyc]), 32'(vecs[i].sync));
            chk($sformatf("fr_data@%0d", vecs[i].cyc), cap_data[vecs[i].cyc], vecs[i].data);
            chk($sformatf("fr_fa@%0d",   vecs[i].cyc), 32'(cap_fa[vecs[i].cyc]), 32'(vecs[i].fa));
            chk($sformatf("fr_cnt@%0d",  vecs[i].cyc), 32'(cap_cnt[vecs[i].cyc]), 32'(vecs[i].cnt));
        end
        chk("fs_count_frame1", 32'(count_fs(0, 92)), 32'd1);

        // Asynchronous reset in the middle of an IM word.
        #2 rst = 1'b1;
        #1;
        chk("arst_sync", 32'(if_a.sync), 32'(S_TR));
        chk("arst_data", if_a.data, 32'h0);
        chk("arst_fa",   32'(if_a.frame_active), 32'h0);
        chk("arst_cnt",  32'(if_a.frame_cnt), 32'h0);
        if_a.mode = 2'd0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Restart from FS/row 0; enable drops during row 2.
        capture(300, -1, 50, -1, -1);
        chk("rs_fa_pre",   32'(cap_fa[22]), 32'h0);
        chk("rs_fs_sync",  32'(cap_sync[23]), 32'(S_FS));
        chk("rs_fs_data",  cap_data[23], 32'h03020100);
        chk("dis_fe_sync", 32'(cap_sync[65]), 32'(S_FE));
        chk("dis_fe_cnt",  32'(cap_cnt[65]), 32'd1);
        chk("dis_fa_off",  32'(cap_fa[66]), 32'h0);
        chk("dis_gap_tr",  32'(cap_sync[70]), 32'(S_TR));
        bad = 0;
        for (int c = 68; c < 300; c++) if (cap_sync[c] != S_TR || cap_fa[c]) bad++;
        chk("dis_idle_tr", 32'(bad), 32'd0);
        chk("dis_cnt_end", 32'(cap_cnt[299]), 32'd1);

        // Trigger mode: pulse in IDLE starts a frame, pulse mid-frame is ignored.
        if_a.use_trigger = 1'b1;
        if_a.enable = 1'b1;
        capture(120, -1, -1, 5, 40);
        chk("trg_pre_tr",  32'(cap_sync[6]), 32'(S_TR));
        chk("trg_ls",      32'(cap_sync[7]), 32'(S_LS));
        chk("trg_fs",      32'(cap_sync[19]), 32'(S_FS));
        chk("trg_fe",      32'(cap_sync[61]), 32'(S_FE));
        chk("trg_fs_cnt",  32'(count_fs(0, 119)), 32'd1);
        chk("trg_cnt",     32'(cap_cnt[119]), 32'd2);

        if_a.mode = 2'd3;
        if_a.const_val = 8'h05;
        capture(80, -1, -1, 5, -1);
        chk("trg2_fs",      32'(cap_sync[19]), 32'(S_FS));
        chk("trg2_const",   cap_data[19], 32'h05050505);
        chk("trg2_cs",      cap_data[27], CS_C5);
        chk("trg2_blk_cs",  cap_data[15], 32'h0);
        chk("trg2_fs_cnt",  32'(count_fs(0, 79)), 32'd1);
        chk("trg2_cnt",     32'(cap_cnt[79]), 32'd3);

        // DUT B: 2 lanes of 10 bits, checkerboard, no black rows.
        if_b.enable = 1'b1;
        for (int c = 0; c < 126; c++) begin
            @(posedge clk);
            #1;
            b_sync[c] = if_b.sync;
            b_data[c] = if_b.data;
        end
        chk("b_gap_sync",  32'(b_sync[1]), 32'(S_TR));
        chk("b_gap_data",  32'(b_data[1]), 32'h55555);
        chk("b_fs_sync",   32'(b_sync[3]), 32'(S_FS));
        chk("b_r0c0",      32'(b_data[3]), 32'h0);
        chk("b_r0c6",      32'(b_data[6]), 32'h0);
        chk("b_r0c8",      32'(b_data[7]), 32'hFFFFF);
        chk("b_cs_sync",   32'(b_sync[13]), 32'(S_CS));
        chk("b_cs_data",   32'(b_data[13]), CS_B);
        chk("b_r8_sync",   32'(b_sync[99]), 32'(S_LS));
        chk("b_r8c0",      32'(b_data[99]), 32'hFFFFF);
        chk("b_r8c8",      32'(b_data[103]), 32'h0);
        chk("b_fe_sync",   32'(b_sync[119]), 32'(S_FE));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
